// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-bus layout, memory-access stage state and constants.
package pipeline_pkg;

  localparam int CTRL_W     = 22;
  localparam int CTRL_IS_ST = 0;
  localparam int CTRL_IS_LD = 1;

  localparam logic [31:0] DEADBEEF = 32'hDEADBEEF;

  typedef enum logic {
    MA_IDLE,
    MA_WAIT
  } ma_state_e;

  // One instruction's worth of EX outputs, as carried through the MA stage
  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       alu_result;
    logic [31:0]       op2;
    logic [31:0]       ir;
    logic [CTRL_W-1:0] ctrl;
  } ma_fields_t;

endpackage

// File: rtl/ma_stage_if.sv
// Data-memory req/ack bus between the MA stage (master) and the data memory (slave).
interface ma_stage_if #(
  parameter int DMEM_AW = 10
);
  logic               dmem_req;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [31:0]        dmem_wdata;
  logic [31:0]        dmem_rdata;
  logic               dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/ma_timeout_counter.sv
// Ack watchdog for the MA stage: loaded on request launch, counts down while waiting.
module ma_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic expire
);
  localparam int W = ($clog2(LIMIT) > 0) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt_q;

  // Loaded with LIMIT-1 so that expire is seen on the LIMIT-th edge after req rises
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    cnt_q <= '0;
    else if (load)                 cnt_q <= W'(LIMIT - 1);
    else if (count && cnt_q != '0) cnt_q <= cnt_q - W'(1);
  end

  assign expire = (cnt_q == '0);
endmodule

// File: rtl/ma_stage.sv
// Memory-access pipeline stage: one ld/st per instruction over a req/ack bus, stalls upstream while waiting.
// Optional ack watchdog enabled by defining MA_STAGE_TIMEOUT_EN.
module ma_stage
  import pipeline_pkg::*;
#(
  parameter int DMEM_AW        = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ma_ready,
  input  logic [31:0]       ex_pc,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_op2,
  input  logic [31:0]       ex_ir,
  input  logic [CTRL_W-1:0] ex_ctrl,
  ma_stage_if.master        dmem,
  output logic              rw_valid,
  output logic [31:0]       rw_pc,
  output logic [31:0]       rw_alu_result,
  output logic [31:0]       rw_ld_result,
  output logic [31:0]       rw_ir,
  output logic [CTRL_W-1:0] rw_ctrl,
  output logic              ma_bus_error
);
  ma_state_e  state_q, state_d;
  ma_fields_t ex_f, hold_q;
  logic       is_mem_in, accept, mem_accept, in_wait, done, bus_err_d;
  logic [31:0] ld_data;

  assign ex_f       = '{pc: ex_pc, alu_result: ex_alu_result, op2: ex_op2, ir: ex_ir, ctrl: ex_ctrl};
  assign is_mem_in  = ex_ctrl[CTRL_IS_ST] | ex_ctrl[CTRL_IS_LD];
  assign in_wait    = (state_q == MA_WAIT);
  assign ma_ready   = (state_q == MA_IDLE);
  assign accept     = ex_valid & ma_ready;
  assign mem_accept = accept & is_mem_in;

`ifdef MA_STAGE_TIMEOUT_EN
  logic expire;

  ma_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .load   (mem_accept),
    .count  (in_wait),
    .expire (expire)
  );

  // An ack on the expiry edge still counts as a normal completion
  assign bus_err_d = in_wait & expire & ~dmem.dmem_ack;
`else
  logic unused_cfg;
  assign unused_cfg = ^32'(TIMEOUT_CYCLES);
  assign bus_err_d  = 1'b0;
`endif

  assign done = in_wait & (dmem.dmem_ack | bus_err_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= MA_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MA_IDLE: if (mem_accept) state_d = MA_WAIT;
      MA_WAIT: if (done)       state_d = MA_IDLE;
      default:                 state_d = MA_IDLE;
    endcase
  end

  // Both IS_LD and IS_ST set behaves as a store, so the store bit decides
  always_comb begin
    ld_data = '0;
    if (!hold_q.ctrl[CTRL_IS_ST]) ld_data = bus_err_d ? DEADBEEF : dmem.dmem_rdata;
  end

  assign dmem.dmem_req   = in_wait;
  assign dmem.dmem_we    = hold_q.ctrl[CTRL_IS_ST];
  assign dmem.dmem_addr  = hold_q.alu_result[DMEM_AW+1:2];
  assign dmem.dmem_wdata = hold_q.op2;

  // rw_* only change at retirement; a pending access lives in hold_q meanwhile
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q        <= '0;
      rw_valid      <= 1'b0;
      rw_pc         <= '0;
      rw_alu_result <= '0;
      rw_ld_result  <= '0;
      rw_ir         <= '0;
      rw_ctrl       <= '0;
      ma_bus_error  <= 1'b0;
    end else begin
      rw_valid     <= 1'b0;
      ma_bus_error <= 1'b0;
      if (mem_accept) hold_q <= ex_f;
      if (accept && !is_mem_in) begin
        rw_valid      <= 1'b1;
        rw_pc         <= ex_pc;
        rw_alu_result <= ex_alu_result;
        rw_ld_result  <= '0;
        rw_ir         <= ex_ir;
        rw_ctrl       <= ex_ctrl;
      end
      if (done) begin
        rw_valid      <= 1'b1;
        rw_pc         <= hold_q.pc;
        rw_alu_result <= hold_q.alu_result;
        rw_ld_result  <= ld_data;
        rw_ir         <= hold_q.ir;
        rw_ctrl       <= hold_q.ctrl;
        ma_bus_error  <= bus_err_d;
      end
    end
  end
endmodule

// File: doc/ma_stage.md
# ma_stage

Memory-access stage of the five-stage pipelined processor, between the EX/MA pipeline latch and the register-writeback stage. Consumes EX outputs: PC, ALU result, op2, IR and the 22-bit control bus. Performs at most one data-memory load or store per instruction over a req/ack handshake, stalling the upstream pipeline while a memory access is outstanding. Non-memory instructions pass through with one cycle of latency.

## Interface
- DMEM_AW, 10, data-memory word-address width (1024 words)
- TIMEOUT_CYCLES, 16, ack watchdog limit (used only with the macro)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX/MA latch holds a valid instruction
- ma_ready  out  1  stage can accept; upstream holds EX/MA when low
- ex_pc, ex_alu_result, ex_op2, ex_ir  in  32 each  EX outputs; alu_result is the byte address for ld/st, op2 is the store data
- ex_ctrl  in  22  control bus
- dmem_req  out  1  access request, held until ack
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  DMEM_AW  word address = alu_result[DMEM_AW+1:2]
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, valid with ack
- dmem_ack  in  1  one-cycle completion pulse
- rw_valid  out  1  one-cycle pulse per retired instruction
- rw_pc, rw_alu_result, rw_ld_result, rw_ir  out  32 each  to writeback
- rw_ctrl  out  22  control bus forwarded
- ma_bus_error  out  1  one-cycle pulse on an aborted access (macro only)

## Operation
- Control-bus bits used: IS_ST=0, IS_LD=1; all other bits are forwarded untouched.
- FSM states: IDLE, WAIT.
- IDLE, ex_valid, neither ld nor st: latch all fields into rw_* and pulse rw_valid on the next cycle. Stay in IDLE.
- IDLE, ex_valid, ld or st: latch the fields. Drive dmem_req=1, dmem_we=IS_ST, addr and wdata from the latched values. Go to WAIT.
- ex_ctrl with both IS_LD and IS_ST set is treated as a store.
- WAIT: hold req, we, addr and wdata stable. On dmem_ack: drop req, capture rdata into rw_ld_result (loads only; stores leave it 0), pulse rw_valid, go to IDLE.
- ma_ready = (state == IDLE). Combinational; no bubble is inserted between back-to-back non-memory instructions.
- dmem_ack while in IDLE is ignored.
- Address bits [1:0] are dropped; no alignment check.

## Timing
- Reset (async, reset=0): state IDLE; every output 0 except ma_ready=1.
- Reset during WAIT abandons the access. Any late ack is ignored.
- Non-memory latency: accepted at edge N, rw_valid high during cycle N+1.
- Memory latency: accepted at edge N, dmem_req high from N+1. If ack is sampled at edge M, then req is low and rw_valid is high during cycle M+1.
- The earliest ack is the edge after req rises, so a memory op costs at least 2 cycles.
- rw_* fields hold their value until the next retirement; only rw_valid pulses.

## Configuration
- MA_STAGE_TIMEOUT_EN defined: a counter runs in WAIT.
  - If ack is not sampled within TIMEOUT_CYCLES edges of req rising, drop req and pulse ma_bus_error together with rw_valid.
  - For a load, rw_ld_result = 32'hDEADBEEF.
  - Return to IDLE.
  - Ack arriving on the same edge as the timeout wins: normal completion, no error.
- Undefined: no counter; WAIT lasts until ack; ma_bus_error tied 0.

## Structure
- Shared package `pipeline_pkg`:
  - CTRL_W=22 and the control-bus bit indices (CTRL_IS_ST, CTRL_IS_LD, plus the existing ones)
  - MA state enum
  - DEADBEEF constant
- One sub-module, `ma_timeout_counter` (load, count, expire), instantiated only under the macro.

## Test plan
- Pass-through: add with alu_result=0x0000_0014 -> rw_valid one cycle later, rw_alu_result=0x14, dmem_req never asserted, ma_ready stays 1.
- Store: alu_result=0x0000_0040, op2=0x1234_5678, ack 3 cycles after req -> dmem_addr=0x010, we=1, wdata=0x12345678 held stable; ma_ready low until the cycle after ack; rw_valid once.
- Load: alu_result=0x0000_0008, ack on the first possible edge with rdata=0xCAFE_F00D -> rw_ld_result=0xCAFEF00D, total 2 cycles.
- Back-to-back: load followed by add with ex_valid held -> the add is accepted only when ma_ready returns; two rw_valid pulses in order; the add's fields are not corrupted.
- Reset in WAIT: reset=0 two cycles after req -> req drops immediately; an ack after reset release produces no rw_valid.
- With MA_STAGE_TIMEOUT_EN and no ack, load -> after 16 cycles, ma_bus_error and rw_valid pulse together, rw_ld_result=0xDEADBEEF; a repeat with ack exactly at the limit completes normally.
